// File: rtl/clk_countdown_timer_pkg.sv
// Purpose: shared types and constants for the countdown timer (field width, field max, FSM encoding).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clk_countdown_timer_pkg;

    localparam int FIELD_W = 8;
    localparam logic [FIELD_W-1:0] MAX_MS_DEF = 8'd59;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Saturate a preset field to the largest legal minute/second value.
    function automatic logic [FIELD_W-1:0] clamp_ms(input logic [FIELD_W-1:0] v,
                                                    input logic [FIELD_W-1:0] max_v);
        return (v > max_v) ? max_v : v;
    endfunction

endpackage

// File: rtl/clk_down_cnt60.sv
// Purpose: one mod-(MAX_MS+1) down-counter field; wraps to MAX_MS when decremented at zero.
// Latency: 1 cycle from clr/load/dec to cnt; borrow is combinational from the held count.
// Backpressure: none; priority clr > load > dec.
module clk_down_cnt60
    import clk_countdown_timer_pkg::*;
#(
    parameter logic [FIELD_W-1:0] MAX_MS = MAX_MS_DEF
)
(
    input  logic               CLK,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               load,
    input  logic [FIELD_W-1:0] load_val,
    input  logic               dec,
    output logic [FIELD_W-1:0] cnt,
    output logic               borrow
);

    // At zero the next decrement must borrow from the next field up.
    assign borrow = (cnt == '0);

    // Field register: clear, load, or step down with wrap.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec) begin
            cnt <= borrow ? MAX_MS : (cnt - 8'd1);
        end
    end

endmodule

// File: rtl/clk_countdown_timer.sv
// Purpose: mm:ss countdown timer with expiry pulse and sticky alarm; COUNTDOWN_AUTO_RELOAD_EN reloads the preset at expiry.
// Latency: 1 cycle from any sampled input to outputs; all status outputs decode registered state.
// Backpressure: none; inputs act in priority rst_counters > load > start/stop > alarm_ack > tick_1hz.
module clk_countdown_timer
    import clk_countdown_timer_pkg::*;
#(
    parameter logic [FIELD_W-1:0] MAX_MS = MAX_MS_DEF
)
(
    input  logic               CLK,
    input  logic               rst_n,
    input  logic               rst_counters,
    input  logic               tick_1hz,
    input  logic               load,
    input  logic [FIELD_W-1:0] load_min,
    input  logic [FIELD_W-1:0] load_sec,
    input  logic               start,
    input  logic               stop,
    input  logic               alarm_ack,
    output logic [FIELD_W-1:0] mins,
    output logic [FIELD_W-1:0] secs,
    output logic               running,
    output logic               expired,
    output logic               alarm
);

    state_t             state_q, state_d;
    logic               expired_q;
    logic [FIELD_W-1:0] pre_min_q, pre_sec_q;
    logic [FIELD_W-1:0] ld_min_c, ld_sec_c;
    logic [FIELD_W-1:0] cnt_min_val, cnt_sec_val;
    logic               cnt_load, cnt_dec;
    logic               expire_evt, reload_evt;
    logic               sec_zero, min_zero;
    logic               count_zero, count_one;

    assign ld_min_c   = clamp_ms(load_min, MAX_MS);
    assign ld_sec_c   = clamp_ms(load_sec, MAX_MS);
    assign count_zero = sec_zero && min_zero;
    // The tick that leaves 00:01 is the one that produces 00:00.
    assign count_one  = min_zero && (secs == 8'd1);

    // A reload at expiry reuses the counters' load path with the stored preset.
    assign cnt_load    = load || reload_evt;
    assign cnt_min_val = load ? ld_min_c : pre_min_q;
    assign cnt_sec_val = load ? ld_sec_c : pre_sec_q;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic preset_zero;
    assign preset_zero = (pre_min_q == '0) && (pre_sec_q == '0);
`endif

    clk_down_cnt60 #(.MAX_MS(MAX_MS)) u_sec_cnt (
        .CLK      (CLK),
        .rst_n    (rst_n),
        .clr      (rst_counters),
        .load     (cnt_load),
        .load_val (cnt_sec_val),
        .dec      (cnt_dec),
        .cnt      (secs),
        .borrow   (sec_zero)
    );

    clk_down_cnt60 #(.MAX_MS(MAX_MS)) u_min_cnt (
        .CLK      (CLK),
        .rst_n    (rst_n),
        .clr      (rst_counters),
        .load     (cnt_load),
        .load_val (cnt_min_val),
        .dec      (cnt_dec && sec_zero),
        .cnt      (mins),
        .borrow   (min_zero)
    );

    // Next state and counter strobes, resolving inputs in priority order.
    always_comb begin
        state_d    = state_q;
        cnt_dec    = 1'b0;
        expire_evt = 1'b0;
        reload_evt = 1'b0;
        if (rst_counters) begin
            state_d = IDLE;
        end else if (load) begin
            state_d = IDLE;
        end else if (stop) begin
            // stop also swallows a coincident start and tick
            if (state_q == RUN) begin
                state_d = PAUSE;
            end
        end else if (start && ((state_q == IDLE) || (state_q == PAUSE))) begin
            if (!count_zero) begin
                state_d = RUN;
            end
        end else if (alarm_ack && (state_q == DONE)) begin
            state_d = IDLE;
        end else if (tick_1hz && (state_q == RUN)) begin
            cnt_dec = 1'b1;
            if (count_one) begin
                expire_evt = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                if (preset_zero) begin
                    state_d = DONE;
                end else begin
                    reload_evt = 1'b1;
                end
`else
                state_d = DONE;
`endif
            end
        end
    end

    // State register and registered expiry pulse.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            expired_q <= expire_evt;
        end
    end

    // Preset capture, clamped exactly as the live count.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            pre_min_q <= '0;
            pre_sec_q <= '0;
        end else if (load && !rst_counters) begin
            pre_min_q <= ld_min_c;
            pre_sec_q <= ld_sec_c;
        end
    end

    assign running = (state_q == RUN);
    assign alarm   = (state_q == DONE);
    assign expired = expired_q;

endmodule

// File: tb/tb_clk_countdown_timer.sv
// Purpose: self-checking bench for clk_countdown_timer against a total-seconds reference model.
// Latency: outputs compared 1 ns after each rising edge.
// Backpressure: n/a.
module tb_clk_countdown_timer;

    localparam int MAXV = 59;
    localparam int MODV = MAXV + 1;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic       CLK = 1'b0;
    logic       rst_n;
    logic       rst_counters;
    logic       tick_1hz;
    logic       load;
    logic [7:0] load_min;
    logic [7:0] load_sec;
    logic       start;
    logic       stop;
    logic       alarm_ack;
    logic [7:0] mins;
    logic [7:0] secs;
    logic       running;
    logic       expired;
    logic       alarm;

    int n_run  = 0;
    int n_fail = 0;

    // Reference model: whole count kept as seconds remaining.
    int m_state;
    int m_rem;
    int m_pre;
    bit m_exp;

    clk_countdown_timer dut (
        .CLK          (CLK),
        .rst_n        (rst_n),
        .rst_counters (rst_counters),
        .tick_1hz     (tick_1hz),
        .load         (load),
        .load_min     (load_min),
        .load_sec     (load_sec),
        .start        (start),
        .stop         (stop),
        .alarm_ack    (alarm_ack),
        .mins         (mins),
        .secs         (secs),
        .running      (running),
        .expired      (expired),
        .alarm        (alarm)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int clampv(input int v);
        return (v > MAXV) ? MAXV : v;
    endfunction

    function automatic void model_reset();
        m_state = M_IDLE;
        m_rem   = 0;
        m_pre   = 0;
        m_exp   = 1'b0;
    endfunction

    function automatic void model_step(input bit rc, input bit ld, input int lm, input int ls,
                                       input bit st, input bit sp, input bit ack, input bit tk);
        m_exp = 1'b0;
        if (rc) begin
            m_rem   = 0;
            m_state = M_IDLE;
        end else if (ld) begin
            m_rem   = clampv(lm) * MODV + clampv(ls);
            m_pre   = m_rem;
            m_state = M_IDLE;
        end else if (sp) begin
            if (m_state == M_RUN) m_state = M_PAUSE;
        end else if (st && (m_state == M_IDLE || m_state == M_PAUSE)) begin
            if (m_rem != 0) m_state = M_RUN;
        end else if (ack && m_state == M_DONE) begin
            m_state = M_IDLE;
        end else if (tk && m_state == M_RUN) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                m_exp = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                if (m_pre != 0) m_rem = m_pre;
                else m_state = M_DONE;
`else
                m_state = M_DONE;
`endif
            end
        end
    endfunction

    task automatic check_model(input string ctx);
        chk({ctx, ".mins"},    32'(mins),    32'(m_rem / MODV));
        chk({ctx, ".secs"},    32'(secs),    32'(m_rem % MODV));
        chk({ctx, ".running"}, 32'(running), 32'(m_state == M_RUN));
        chk({ctx, ".expired"}, 32'(expired), 32'(m_exp));
        chk({ctx, ".alarm"},   32'(alarm),   32'(m_state == M_DONE));
    endtask

    // One clock of stimulus: drive, take the edge, step the model, compare.
    task automatic cyc(input bit rc, input bit ld, input int lm, input int ls,
                       input bit st, input bit sp, input bit ack, input bit tk);
        rst_counters = rc;
        load         = ld;
        load_min     = 8'(lm);
        load_sec     = 8'(ls);
        start        = st;
        stop         = sp;
        alarm_ack    = ack;
        tick_1hz     = tk;
        @(posedge CLK);
        model_step(rc, ld, lm, ls, st, sp, ack, tk);
        #1;
        check_model("cyc");
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    // Called 1 ns after an edge: pulls rst_n low between edges and checks outputs drop at once.
    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #2;
        chk({tag, ".mins"},    32'(mins),    32'd0);
        chk({tag, ".secs"},    32'(secs),    32'd0);
        chk({tag, ".running"}, 32'(running), 32'd0);
        chk({tag, ".expired"}, 32'(expired), 32'd0);
        chk({tag, ".alarm"},   32'(alarm),   32'd0);
        model_reset();
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n        = 1'b0;
        rst_counters = 1'b0;
        tick_1hz     = 1'b0;
        load         = 1'b0;
        load_min     = 8'd0;
        load_sec     = 8'd0;
        start        = 1'b0;
        stop         = 1'b0;
        alarm_ack    = 1'b0;
        model_reset();
        #3;
        check_model("reset");
        #4;
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        check_model("post_reset");

        // 01:00 borrows to 00:59
        cyc(0, 1, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        ticks(1);
        chk("borrow.mins", 32'(mins), 32'd0);
        chk("borrow.secs", 32'(secs), 32'd59);
        chk("borrow.running", 32'(running), 32'd1);
        chk("borrow.expired", 32'(expired), 32'd0);

        // 00:02 runs out; expiry pulse for exactly one cycle
        cyc(0, 1, 0, 2, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        ticks(2);
        chk("expire.pulse", 32'(expired), 32'd1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("expire.pulse_end", 32'(expired), 32'd0);
        ticks(1);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);

        // clamping, then start refused at 00:00
        cyc(0, 1, 75, 80, 0, 0, 0, 0);
        chk("clamp.mins", 32'(mins), 32'd59);
        chk("clamp.secs", 32'(secs), 32'd59);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        chk("zero_start.running", 32'(running), 32'd0);

        // pause and resume
        cyc(0, 1, 0, 10, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        ticks(3);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        ticks(5);
        chk("pause.secs", 32'(secs), 32'd7);
        cyc(0, 0, 0, 0, 1, 1, 0, 0);
        chk("start_stop.running", 32'(running), 32'd0);
        cyc(0, 0, 0, 0, 1, 0, 0, 1);
        chk("resume_tick.secs", 32'(secs), 32'd7);
        ticks(1);
        chk("resume.secs", 32'(secs), 32'd6);

        // asynchronous reset mid-run
        async_reset("arst");
        cyc(0, 0, 0, 0, 0, 0, 0, 0);

        // rst_counters beats a coincident tick at 00:05
        cyc(0, 1, 0, 7, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        ticks(2);
        cyc(1, 0, 0, 0, 0, 0, 0, 1);
        chk("rc_tick.secs", 32'(secs), 32'd0);
        chk("rc_tick.expired", 32'(expired), 32'd0);

        // repeated expiry (reload build keeps running)
        cyc(0, 1, 0, 2, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        ticks(4);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bit rc, ld, st, sp, ack, tk;
            int lm, ls;
            rc  = ($urandom_range(0, 199) == 0);
            ld  = ($urandom_range(0, 39) == 0);
            st  = ($urandom_range(0, 7) == 0);
            sp  = ($urandom_range(0, 24) == 0);
            ack = ($urandom_range(0, 9) == 0);
            tk  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) == 0) begin
                lm = int'($urandom_range(0, 255));
                ls = int'($urandom_range(0, 255));
            end else begin
                lm = int'($urandom_range(0, 1));
                ls = int'($urandom_range(0, 4));
            end
            cyc(rc, ld, lm, ls, st, sp, ack, tk);
            if ($urandom_range(0, 599) == 0) async_reset("rand_arst");
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_countdown_timer.md
# clk_countdown_timer

Countdown timer for the digital clock: loads a mm:ss preset, then decrements seconds with borrow into minutes on each 1 Hz tick until 00:00, where it raises an expiry pulse and a sticky alarm. Its carry runs the opposite way to the clock's count-up chain, which ripples seconds to minutes to hours: here seconds borrow from minutes. It shares the clock's `CLK`, `rst_n` and 1 Hz tick, and feeds the display mux and the buzzer driver.

## Interface
- `MAX_MS`, default 59: maximum value of the minute and second fields. Loads above it are clamped to it.
- `CLK` in 1: system clock. All state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rst_counters` in 1: synchronous clear to 00:00, state IDLE.
- `tick_1hz` in 1: one-cycle pulse, once per second.
- `load` in 1: capture the preset.
- `load_min` in 8: preset minutes.
- `load_sec` in 8: preset seconds.
- `start` in 1: begin or resume counting.
- `stop` in 1: pause counting.
- `alarm_ack` in 1: clear the alarm.
- `mins` out 8: current minutes. Reset 0.
- `secs` out 8: current seconds. Reset 0.
- `running` out 1: high in state RUN. Reset 0.
- `expired` out 1: one-cycle pulse on reaching 00:00. Reset 0.
- `alarm` out 1: sticky, high in state DONE. Reset 0.

## Operation
- States:
  - IDLE: reset state.
  - RUN: counting.
  - PAUSE: count held.
  - DONE: count reached 00:00, alarm held.
- Input priority, highest first: `rst_counters`, `load`, `start`/`stop`, `alarm_ack`, `tick_1hz`.
- `rst_counters`:
  - mins = secs = 0; state becomes IDLE.
  - `alarm` and `expired` are forced 0.
- `load`:
  - mins = min(`load_min`, MAX_MS) and secs = min(`load_sec`, MAX_MS); the values are also stored as the preset.
  - Accepted in every state. State becomes IDLE and `alarm` clears.
- `start`:
  - From IDLE or PAUSE, goes to RUN only if the count is nonzero; at 00:00 it is ignored.
  - Ignored in RUN and DONE.
- `stop`:
  - RUN goes to PAUSE.
  - If `start` and `stop` are asserted together, `stop` wins.
- `tick_1hz` in RUN:
  - secs > 0: secs - 1.
  - secs = 0 and mins > 0: secs = MAX_MS, mins - 1 (borrow).
  - Ticks are ignored in every other state.
- Expiry:
  - Occurs on the tick that produces 00:00.
  - Registers update to 00:00; state becomes DONE and `expired` is high for that one cycle.
- `alarm_ack` in DONE: state goes to IDLE, count stays 00:00.
- Arithmetic: unsigned 8-bit fields; the count never underflows below 00:00.

## Timing
- Every input acts on the rising edge where it is sampled; outputs update that edge, so latency is 1 cycle.
- `running`, `alarm` and `expired` are decoded from registered state, not from inputs (glitch-free).
- `rst_n` assertion mid-count: all outputs go to 0 immediately (asynchronously). After release the block stays in IDLE until `load`/`start`.
- A tick coincident with `load`, `stop` or `rst_counters` is discarded.
- A tick coincident with `start` from PAUSE is discarded. The first decrement happens on the next tick.

## Configuration
- `COUNTDOWN_AUTO_RELOAD_EN` defined:
  - At expiry the block reloads the stored preset instead of entering DONE, and stays in RUN.
  - `expired` still pulses for one cycle; `alarm` stays 0.
  - A stored preset of 00:00 still enters DONE.
- Not defined: the block stops in DONE as described in Operation.

## Structure
- Shared clock package holds:
  - `MAX_MS` default (59).
  - The state encoding, a typedef with IDLE=0, RUN=1, PAUSE=2, DONE=3.
  - The 8-bit field width constant.
- Sub-module `clk_down_cnt60`: one mod-(MAX_MS+1) down-counter with inputs dec, load, clr and a borrow output. It is instantiated twice, seconds then minutes.
- The FSM and preset registers live in the top level.

## Test plan
- Load 01:00, start, 1 tick -> mins=0, secs=59, `running`=1. No `expired`.
- Load 00:02, start, 2 ticks -> 00:00. `expired` is high exactly one cycle on the 2nd tick edge, then `alarm`=1. A 3rd tick changes nothing. `alarm_ack` -> `alarm`=0, state IDLE.
- Load `load_min`=75, `load_sec`=80 -> mins=59, secs=59. Start at 00:00 after `rst_counters` -> `running` stays 0.
- Load 00:10, start, 3 ticks -> 00:07. `stop`, 5 ticks -> still 00:07. `start`+`stop` together -> remains PAUSE. `start`, 1 tick -> 00:06.
- Mid-run: `rst_n` low -> all outputs 0 without waiting for a clock edge. `rst_counters` coincident with a tick at 00:05 -> 00:00, IDLE, no `expired`.
- With `COUNTDOWN_AUTO_RELOAD_EN`: load 00:02, start, 2 ticks -> `expired` pulse, count becomes 00:02, `running`=1, `alarm`=0. 2 more ticks -> second pulse.
